// File: rtl/mem_arbiter.sv
// Two-client arbiter/sequencer in front of a single-port synchronous RAM.
// Optional MEM_ARB_FIXED_PRIO_EN: client 0 wins every tie instead of round-robin.
module mem_arbiter #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic             we0,
   input  logic             we1,
   input  logic [DEPTH-1:0] addr0,
   input  logic [DEPTH-1:0] addr1,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             rvalid0,
   output logic             rvalid1,
   output logic [WIDTH-1:0] rdata0,
   output logic [WIDTH-1:0] rdata1,
   output logic             en,
   output logic             mem_write,
   output logic [DEPTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_write_data,
   input  logic [WIDTH-1:0] mem_read_data
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RD_WAIT
   } state_t;

   state_t state_q, state_d;
   logic   cur_q, cur_d;
   logic   pick1;
   logic   any_req;

   logic             gnt0_d, gnt1_d;
   logic             rv0_d, rv1_d;
   logic [WIDTH-1:0] rd0_d, rd1_d;
   logic             en_d, mw_d;
   logic [DEPTH-1:0] addr_d;
   logic [WIDTH-1:0] wd_d;

   assign any_req = req0 | req1;

`ifdef MEM_ARB_FIXED_PRIO_EN
   // client 0 takes every tie
   assign pick1 = ~req0;
`else
   logic last_gnt;

   // a tie goes to the client not served last time
   assign pick1 = req1 & (~req0 | ~last_gnt);

   // remember the most recent winner
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_gnt <= 1'b1;
      else if (state_q == IDLE && any_req)
         last_gnt <= pick1;
   end
`endif

   // next-state and next-output values for every register
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      rv0_d   = 1'b0;
      rv1_d   = 1'b0;
      rd0_d   = rdata0;
      rd1_d   = rdata1;
      en_d    = 1'b0;
      mw_d    = 1'b0;
      addr_d  = mem_addr;
      wd_d    = mem_write_data;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               cur_d   = pick1;
               gnt0_d  = ~pick1;
               gnt1_d  = pick1;
               en_d    = 1'b1;
               mw_d    = pick1 ? we1 : we0;
               addr_d  = pick1 ? addr1 : addr0;
               wd_d    = pick1 ? wdata1 : wdata0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = mem_write ? IDLE : RD_WAIT;
         end
         RD_WAIT: begin
            if (cur_q) begin
               rd1_d = mem_read_data;
               rv1_d = 1'b1;
            end else begin
               rd0_d = mem_read_data;
               rv0_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cur_q          <= 1'b0;
         gnt0           <= 1'b0;
         gnt1           <= 1'b0;
         rvalid0        <= 1'b0;
         rvalid1        <= 1'b0;
         rdata0         <= '0;
         rdata1         <= '0;
         en             <= 1'b0;
         mem_write      <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
      end else begin
         state_q        <= state_d;
         cur_q          <= cur_d;
         gnt0           <= gnt0_d;
         gnt1           <= gnt1_d;
         rvalid0        <= rv0_d;
         rvalid1        <= rv1_d;
         rdata0         <= rd0_d;
         rdata1         <= rd1_d;
         en             <= en_d;
         mem_write      <= mw_d;
         mem_addr       <= addr_d;
         mem_write_data <= wd_d;
      end
   end

endmodule
